// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder and driver.
// Holds the one-hot FSM encoding and small sizing helpers.
package systolic_pkg;

    typedef enum logic [5:0] {
        LOAD_S  = 6'b000001,
        SEND_S  = 6'b000010,
        WAIT_S  = 6'b000100,
        DRAIN_S = 6'b001000,
        FLUSH_S = 6'b010000,
        DONE_S  = 6'b100000
    } state_e;

    // Counter/pointer width for a range of n values, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_feeder_counter.sv
// Up-counter with synchronous clear and increment enable.
// Clear wins over increment; wrap handling is left to the caller.
module matrix_feeder_counter #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_d;
    logic [width_p-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/matrix_feeder.sv
// Buffers one job of depth_p steps of (W+H) words from the host, then streams
// each word hold_p times per step to the array driver, handshaking on busy_i.
module matrix_feeder
    import systolic_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2,
    parameter int hold_p         = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o,
    input  logic               busy_i,
    output logic               flush_o,
    output logic               done_o
);

    localparam int step_words_lp = array_width_p + array_height_p;
    localparam int words_lp      = depth_p * step_words_lp;
    localparam int ptr_w_lp      = ptr_width(words_lp);
    localparam int hold_w_lp     = ptr_width(hold_p);
    localparam int step_w_lp     = ptr_width(depth_p);

    localparam logic [ptr_w_lp-1:0]  last_ptr_lp  = ptr_w_lp'(words_lp - 1);
    localparam logic [hold_w_lp-1:0] hold_last_lp = hold_w_lp'(hold_p - 1);
    localparam logic [step_w_lp-1:0] step_last_lp = step_w_lp'(depth_p - 1);

    state_e               state_q, state_d;
    logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
    logic [step_w_lp-1:0] step_cnt_q, step_cnt_d;
    logic [width_p-1:0]   mem_q [words_lp];
    logic [width_p-1:0]   mem_d [words_lp];
    logic [hold_w_lp-1:0] hold_cnt;
    logic                 hold_inc;
    logic                 hold_clr;
    logic                 last_of_step;

    // The last word of the current step sits at (step_cnt+1)*(W+H)-1.
    assign last_of_step = (int'(rd_ptr_q) == (int'(step_cnt_q) + 1) * step_words_lp - 1);

    matrix_feeder_counter #(
        .width_p (hold_w_lp)
    ) u_hold_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (hold_clr),
        .inc_i   (hold_inc),
        .count_o (hold_cnt)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        step_cnt_d = step_cnt_q;
        mem_d      = mem_q;
        hold_inc   = 1'b0;
        hold_clr   = 1'b0;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        flush_o    = 1'b0;
        done_o     = 1'b0;
        data_o     = mem_q[rd_ptr_q];

        unique case (state_q)
            LOAD_S: begin
                ready_o = 1'b1;
                if (valid_i && en_i) begin
                    mem_d[wr_ptr_q] = data_i;
                    if (wr_ptr_q == last_ptr_lp) begin
                        state_d = SEND_S;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            SEND_S: begin
                valid_o = 1'b1;
                if (ready_i && en_i) begin
                    if (hold_cnt == hold_last_lp) begin
                        hold_clr = 1'b1;
                        // Park on the final word rather than wrapping the pointer.
                        if (rd_ptr_q != last_ptr_lp) begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                        if (last_of_step) begin
                            state_d = WAIT_S;
                        end
                    end else begin
                        hold_inc = 1'b1;
                    end
                end
            end
            WAIT_S: begin
                if (en_i && busy_i) begin
                    state_d = DRAIN_S;
                end
            end
            DRAIN_S: begin
                if (en_i && !busy_i) begin
                    if (step_cnt_q == step_last_lp) begin
                        state_d = FLUSH_S;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                        state_d    = SEND_S;
                    end
                end
            end
            FLUSH_S: begin
                flush_o = en_i;
                if (en_i) begin
                    state_d = DONE_S;
                end
            end
            DONE_S: begin
                done_o = en_i;
                if (en_i) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    step_cnt_d = '0;
                    state_d    = LOAD_S;
                end
            end
            default: begin
                state_d = LOAD_S;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= LOAD_S;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder at default parameters (W=H=2, K=2, hold=2).
// Records every accepted array-side word and compares against hand-built streams.
module tb_matrix_feeder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        busy_i;
    logic        flush_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    matrix_feeder dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .busy_i  (busy_i),
        .flush_o (flush_o),
        .done_o  (done_o)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          flush_cnt = 0;
    int          done_cnt = 0;
    int          flush_cyc = 0;
    int          done_cyc = 0;
    logic        auto_busy = 1'b1;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs just before the edge, then settle past the falling edge.
    task automatic tick();
        #1;
        if (valid_o && ready_i && en_i) got_q.push_back(data_o);
        if (flush_o) begin flush_cnt++; flush_cyc = cyc; end
        if (done_o)  begin done_cnt++;  done_cyc  = cyc; end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        // Act as the driver: one busy pulse whenever the feeder sits idle between steps.
        if (auto_busy)
            busy_i = (!valid_o && !ready_o && !flush_o && !done_o && !busy_i);
    endtask

    task automatic new_job();
        flush_cnt = 0;
        done_cnt  = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic load_words(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = base + 32'(i);
            exp_q.push_back(base + 32'(i));
            exp_q.push_back(base + 32'(i));
            tick();
        end
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic run_to_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_word"}, (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    endtask

    initial begin
        reset_i = 1'b1;
        en_i    = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        busy_i  = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        reset_i = 1'b0;

        // Basic job: 1,1,2,2,3,3,4,4 then 5..8 after the busy handshake.
        new_job();
        load_words(32'd1);
        chk("lat_valid", 32'(valid_o), 32'd1);
        chk("lat_data",  data_o, 32'd1);
        chk("lat_ready", 32'(ready_o), 32'd0);
        run_to_done("j1");
        check_stream("j1");
        chk("j1_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("j1_done_cnt",  32'(done_cnt),  32'd1);
        chk("j1_done_after_flush", 32'(done_cyc - flush_cyc), 32'd1);
        chk("j1_back_to_load", 32'(ready_o), 32'd1);

        // ready_i stall during the second hold cycle of word 2.
        new_job();
        load_words(32'h10);
        repeat (3) tick();
        chk("stall_pre", data_o, 32'h11);
        ready_i = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_hold", data_o, 32'h11);
        end
        ready_i = 1'b1;
        tick();
        chk("stall_next", data_o, 32'h12);
        run_to_done("j2");
        check_stream("j2");

        // en_i low freezes everything mid-stream.
        new_job();
        load_words(32'h20);
        repeat (5) tick();
        chk("en_pre", data_o, 32'h22);
        en_i = 1'b0;
        repeat (4) begin
            tick();
            chk("en_hold_data",  data_o, 32'h22);
            chk("en_hold_valid", 32'(valid_o), 32'd1);
        end
        en_i = 1'b1;
        tick();
        chk("en_next", data_o, 32'h23);
        run_to_done("j3");
        check_stream("j3");

        // Host writes while streaming are ignored.
        new_job();
        load_words(32'h30);
        valid_i = 1'b1;
        data_i  = 32'hDEAD;
        repeat (6) begin
            tick();
            chk("ign_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        data_i  = '0;
        run_to_done("j4");
        check_stream("j4");

        // Reset during the second step aborts silently; a reload replays cleanly.
        new_job();
        load_words(32'h40);
        begin
            int n = 0;
            while (got_q.size() < 10 && n < 100) begin
                tick();
                n++;
            end
            chk("rr_reach_step2", 32'(got_q.size() >= 10), 32'd1);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rr_ready", 32'(ready_o), 32'd1);
        chk("rr_valid", 32'(valid_o), 32'd0);
        chk("rr_flush_out", 32'(flush_o), 32'd0);
        chk("rr_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rr_done_cnt",  32'(done_cnt),  32'd0);
        new_job();
        load_words(32'h50);
        run_to_done("j5");
        check_stream("j5");
        chk("j5_flush_cnt", 32'(flush_cnt), 32'd1);

        // Driver never goes busy: feeder parks after step 1.
        new_job();
        load_words(32'h60);
        auto_busy = 1'b0;
        busy_i    = 1'b0;
        repeat (40) tick();
        chk("park_valid", 32'(valid_o), 32'd0);
        chk("park_ready", 32'(ready_o), 32'd0);
        chk("park_flush", 32'(flush_cnt), 32'd0);
        chk("park_done",  32'(done_cnt),  32'd0);
        chk("park_words", 32'(got_q.size()), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
